// File: rtl/signal_source_multi.sv
// Per-channel two-stage DDR source MUX with select-write handshake and settle window.
// Data latency 2 registers; sel_ready_o drops for HOLD+1 cycles after an accepted select change.
module signal_source_multi #(
  parameter int WIDTH = 24,
  parameter int SBITS = 5,
  parameter int QBITS = SBITS - 2,
  parameter int CHANS = 2,
  parameter int HOLD  = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic [CHANS*SBITS-1:0] select_i,
  input  logic                   sel_we_i,
  output logic                   sel_ready_o,
  output logic                   sel_err_o,
  input  logic [WIDTH-1:0]       sig_p_i,
  input  logic [WIDTH-1:0]       sig_n_i,
  output logic                   valid_o,
  output logic [CHANS-1:0]       sig_p_o,
  output logic [CHANS-1:0]       sig_n_o
);

  localparam int NQ    = 2**QBITS;
  localparam int HBITS = SBITS - QBITS;
  localparam int NG    = 2**HBITS;
  localparam int PADW  = NG * NQ;
  localparam int CW    = $clog2(HOLD + 2);

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [CHANS*SBITS-1:0] r_sel;
  logic                   r_err;
  logic [PADW-1:0]        w_p_pad, w_n_pad;
  logic [NQ-1:0]          r_s1_p  [CHANS];
  logic [NQ-1:0]          r_s1_n  [CHANS];
  logic [QBITS-1:0]       r_s1_lo [CHANS];
  logic [CHANS-1:0]       r_out_p, r_out_n;
  logic                   w_sel_ok, w_accept, w_reject;

  always_comb begin
    w_sel_ok = 1'b1;
    for (int c = 0; c < CHANS; c++) begin
      if ({1'b0, select_i[c*SBITS +: SBITS]} >= (SBITS+1)'(WIDTH)) w_sel_ok = 1'b0;
    end
  end

  assign sel_ready_o = !((r_state == ST_WAIT) && (r_cnt != '0));
  assign w_accept    = sel_we_i && sel_ready_o && w_sel_ok;
  assign w_reject    = sel_we_i && sel_ready_o && !w_sel_ok;
  assign valid_o     = (r_state == ST_RUN);
  assign sel_err_o   = r_err;
  assign sig_p_o     = r_out_p;
  assign sig_n_o     = r_out_n;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_sel <= select_i;
      if (w_reject) r_err <= 1'b1;
    end
  end

  // Inputs are zero-extended so groups reaching past WIDTH read as 0.
  always_comb begin
    w_p_pad = '0;
    w_n_pad = '0;
    w_p_pad[WIDTH-1:0] = sig_p_i;
    w_n_pad[WIDTH-1:0] = sig_n_i;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int c = 0; c < CHANS; c++) begin
        r_s1_p[c]  <= '0;
        r_s1_n[c]  <= '0;
        r_s1_lo[c] <= '0;
      end
      r_out_p <= '0;
      r_out_n <= '0;
    end else begin
      for (int c = 0; c < CHANS; c++) begin
        r_s1_p[c]  <= w_p_pad[int'(r_sel[c*SBITS+QBITS +: HBITS])*NQ +: NQ];
        r_s1_n[c]  <= w_n_pad[int'(r_sel[c*SBITS+QBITS +: HBITS])*NQ +: NQ];
        r_s1_lo[c] <= r_sel[c*SBITS +: QBITS];
        r_out_p[c] <= r_s1_p[c][r_s1_lo[c]];
        r_out_n[c] <= r_s1_n[c][r_s1_lo[c]];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (enable_i) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (!enable_i)            w_state_nxt = ST_OFF;
        else if (r_cnt == '0)     w_state_nxt = ST_RUN;
        else                      w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_RUN: begin
        if (!enable_i) w_state_nxt = ST_OFF;
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
    // A new selection restarts blanking; disable and OFF keep their own outcome.
    if (w_accept && enable_i && (r_state != ST_OFF)) begin
      w_state_nxt = ST_WAIT;
      w_cnt_nxt   = CW'(HOLD + 1);
    end
  end

endmodule

// File: doc/signal_source_multi.md
# signal_source_multi

Parametrised, multi-channel successor to the two-stage DDR source multiplexer. Selects CHANS independent signal-sources from WIDTH DDR antenna inputs (posedge and negedge streams), each through a registered two-stage MUX. Adds a select-write handshake, rejection of out-of-range selects, and a settle window that deasserts valid while the pipeline flushes after a source change. Sits in the sampling-clock domain between the capture front-end and the per-channel clock-recovery blocks.

## Interface

- WIDTH, 24: number of input signal-sources.
- SBITS, 5: select-field width per channel; 2**SBITS >= WIDTH; SBITS >= 3.
- QBITS, SBITS-2: low select bits resolved in the second MUX stage.
- CHANS, 2: number of independent output channels.
- HOLD, 4: extra blanking cycles after an accepted select change; range 0..15.

- clock_i  in  1  sampling clock, half-rate/DDR; all logic on posedge.
- reset_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  core enable.
- select_i  in  CHANS*SBITS  packed select fields; channel c uses bits [c*SBITS +: SBITS].
- sel_we_i  in  1  select-write request.
- sel_ready_o  out  1  select-write may be accepted.
- sel_err_o  out  1  sticky out-of-range select flag.
- sig_p_i  in  WIDTH  posedge DDR samples.
- sig_n_i  in  WIDTH  negedge DDR samples.
- valid_o  out  1  all channel outputs carry the current selection.
- sig_p_o  out  CHANS  per-channel posedge MUX output, registered.
- sig_n_o  out  CHANS  per-channel negedge MUX output, registered.

## Operation

- Reset (reset_ni low, asynchronous): state OFF, counter 0, select registers 0, stage registers 0, sig_p_o = sig_n_o = 0, valid_o = 0, sel_err_o = 0, sel_ready_o = 1.
- Select register sel_q (CHANS*SBITS) is loaded from select_i at an edge where sel_we_i = 1 and sel_ready_o = 1, and every field is < WIDTH.
- If any field is >= WIDTH: the whole write is rejected, sel_q unchanged, sel_err_o set to 1 at that edge; it is cleared only by reset. A rejected write causes no state change.
- Datapath per channel, always running regardless of state:
  - Stage 1: registers the 2**QBITS-bit slice of sig_p_i / sig_n_i starting at bit sel_q[high SBITS-QBITS bits] * 2**QBITS; bits beyond WIDTH read as 0. Registers the low QBITS of sel_q alongside.
  - Stage 2: sig_p_o / sig_n_o <= stage-1 slice indexed by the registered low bits.
- Control FSM, states OFF, WAIT, RUN; counter width sufficient for HOLD+1:
  - OFF: if enable_i, go WAIT with counter 0.
  - WAIT: if !enable_i, go OFF; else if counter == 0, go RUN; else counter decrements.
  - RUN: if !enable_i, go OFF.
  - An accepted write while enable_i = 1 (state WAIT-from-fill or RUN) forces WAIT with counter HOLD+1, overriding the above. An accepted write in OFF leaves state OFF.
- valid_o = (state == RUN), taken directly from the state register.
- sel_ready_o = 0 only in WAIT with counter > 0, i.e. a settle window; writes during fill (counter 0) are accepted.
- enable_i low takes priority over a simultaneous write's state effect (state goes OFF); the write still updates sel_q if valid.

## Timing

- Data latency: input present at edge k appears on sig_*_o after edge k+1, which is 2 registers.
- Enable: enable_i first sampled high at edge k in OFF gives valid_o = 1 after edge k+1.
- Select change: write accepted at edge w gives new-source data on outputs after edge w+2; valid_o = 0 after edge w; valid_o = 1 after edge w+2+HOLD (HOLD = 0: after w+2); sel_ready_o = 1 again after edge w+1+HOLD.
- Disable: enable_i sampled low at edge d gives valid_o = 0 after edge d.
- Reset mid-operation: all outputs return to reset values immediately, with no clock required.

## Test plan

- Reset/enable: WIDTH=24, CHANS=2, HOLD=4; release reset, enable_i=1 at edge 0 -> valid_o=1 after edge 1; sig_*_o[0..1] track source 0 with 2-register latency.
- Source sweep: write each select 0..23 to both channels (channel 1 = 23-c) with walking-one sig_p_i and inverted sig_n_i -> after valid, sig_p_o[c] and sig_n_o[c] match the chosen bits for all 24 values.
- Settle window: in RUN, write select {5,17} at edge w -> valid_o low for edges w..w+5, high after w+6; sel_ready_o low after w, high after w+5; a write at w+3 is ignored.
- Out-of-range: write field 0 = 24 -> sel_err_o=1, sel_q unchanged, valid_o stays 1; sel_err_o stays 1 until reset_ni pulses low.
- Disable/boundary: enable_i low during settle -> valid_o=0 after that edge, state OFF; a write in OFF is accepted with no WAIT; re-enable gives valid 1 edge later. HOLD=0 gives valid after w+2.
- Async reset: assert reset_ni between edges while in RUN -> all outputs 0 immediately, sel_ready_o=1.
